// File: rtl/bsh_pkg.sv
// bsh_pkg: shared widths, request payload type and one-hot amount decode for the barrel issue path
package bsh_pkg;
  localparam int BSH_W = 16;
  localparam int BSH_AMT_W = 4;
  typedef struct packed {
    logic [BSH_W-1:0]     data;
    logic [BSH_AMT_W-1:0] amt;
  } bsh_req_t;
  function automatic logic [BSH_W-1:0] onehot16(input logic [BSH_AMT_W-1:0] amt);
    return {{(BSH_W-1){1'b0}}, 1'b1} << amt;
  endfunction
endpackage

// File: rtl/bsh_req_fifo.sv
// bsh_req_fifo: DEPTH-entry request FIFO; ports clk, rst_n, push_i/din_i, pop_i/dout_o, full_o, empty_o, level_o
module bsh_req_fifo
  import bsh_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  bsh_req_t               din_i,
  input  logic                   pop_i,
  output bsh_req_t               dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PW = $clog2(DEPTH);
  bsh_req_t      mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   lvl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  assign dout_o  = mem_q[rd_q];
  assign full_o  = lvl_q == (PW+1)'(DEPTH);
  assign empty_o = lvl_q == '0;
  assign level_o = lvl_q;
endmodule

// File: rtl/bsh_issue_ctrl.sv
// bsh_issue_ctrl: FIFO-buffered two-stage issue/capture around a one-hot barrel (in_* requests, bsh_d/bsh_n/bsh_w barrel, out_* results, fifo_level; op_count when BSH_PERF_CNT_EN is defined)
module bsh_issue_ctrl
  import bsh_pkg::*;
#(
  parameter int DEPTH = 4
`ifdef BSH_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BSH_W-1:0]       in_data,
  input  logic [BSH_AMT_W-1:0]   in_amt,
  output logic [BSH_W-1:0]       bsh_d,
  output logic [BSH_W-1:0]       bsh_n,
  input  logic [BSH_W-1:0]       bsh_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BSH_W-1:0]       out_data,
  output logic [BSH_AMT_W-1:0]   out_amt,
`ifdef BSH_PERF_CNT_EN
  output logic [CNT_W-1:0]       op_count,
`endif
  output logic [$clog2(DEPTH):0] fifo_level
);
  logic                 full, empty, push, pop, s2_load;
  bsh_req_t             head;
  logic                 s1_valid_q, s1_valid_d, out_valid_q, out_valid_d;
  logic [BSH_W-1:0]     s1_data_q, s1_data_d, s1_n_q, s1_n_d, out_data_q, out_data_d;
  logic [BSH_AMT_W-1:0] s1_amt_q, s1_amt_d, out_amt_q, out_amt_d;
  // in_ready depends only on registered occupancy, so a full FIFO refuses even when popping
  assign in_ready = !full;
  assign push     = in_valid & !full;
  assign s2_load  = s1_valid_q & (!out_valid_q | out_ready);
  assign pop      = !empty & (!s1_valid_q | s2_load);
  bsh_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   ('{data: in_data, amt: in_amt}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );
  always_comb begin
    s1_valid_d  = pop | (s1_valid_q & !s2_load);
    s1_data_d   = pop ? head.data : s1_data_q;
    s1_n_d      = pop ? onehot16(head.amt) : s1_n_q;
    s1_amt_d    = pop ? head.amt : s1_amt_q;
    out_valid_d = s2_load | (out_valid_q & !out_ready);
    out_data_d  = s2_load ? bsh_w : out_data_q;
    out_amt_d   = s2_load ? s1_amt_q : out_amt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_n_q      <= '0;
      s1_amt_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_amt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_n_q      <= s1_n_d;
      s1_amt_q    <= s1_amt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_amt_q   <= out_amt_d;
    end
  assign bsh_d     = s1_data_q;
  assign bsh_n     = s1_n_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_amt   = out_amt_q;
`ifdef BSH_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (out_valid_q & out_ready) cnt_q <= cnt_q + 1'b1;
  assign op_count = cnt_q;
`endif
endmodule
